mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit that sits directly downstream of the 32x32 register file.
- Consumes the register file read operands (RD1/RD2 arrive as SrcA/SrcB) for MULT, MULTU, DIV and DIVU.
- Holds the HI and LO architectural registers and supports direct HI/LO writes (MTHI/MTLO).
- The control unit stalls the pipeline while busy=1; HI/LO feed the MFHI/MFLO path back to the register file's WD3 mux.

---
 rtl/mdu_hilo_if.sv | 38 +++
 rtl/mdu_hilo.sv | 185 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: operand/control inputs and HI/LO result bundle for mdu_hilo.
// The divzero signal exists only when MDU_DIVZERO_EN is defined.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] WD;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
`ifdef MDU_DIVZERO_EN
  logic             divzero;

  modport master (
    output start, op, SrcA, SrcB, hi_we, lo_we, WD,
    input  busy, done, HI, LO, divzero
  );
  modport slave (
    input  start, op, SrcA, SrcB, hi_we, lo_we, WD,
    output busy, done, HI, LO, divzero
  );
`else
  modport master (
    output start, op, SrcA, SrcB, hi_we, lo_we, WD,
    input  busy, done, HI, LO
  );
  modport slave (
    input  start, op, SrcA, SrcB, hi_we, lo_we, WD,
    output busy, done, HI, LO
  );
`endif
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MDU_DIVZERO_EN to flag divide-by-zero on divzero instead of writing a fixed result.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  mdu_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic               r_rem_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div0;

  assign w_signed    = ~bus.op[0];
  assign w_a_mag     = (w_signed && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
  assign w_b_mag     = (w_signed && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_prod      = r_neg ? -r_acc : r_acc;
  assign w_quo       = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem       = r_rem_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_div0      = r_div & (r_b == {WIDTH{1'b0}});

`ifdef MDU_DIVZERO_EN
  logic r_divz;
  assign bus.divzero = r_divz;
`else
  // Un-negating the dividend magnitude recovers the raw SrcA captured at start.
  logic [WIDTH-1:0] w_a_raw;
  assign w_a_raw = r_rem_neg ? -r_a : r_a;
`endif

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

  // One iteration: shift-add multiply (product fills from the top) or restoring divide.
  always_comb begin
    w_acc_step = r_acc;
    if (r_div) begin
      if (!w_div_trial[WIDTH]) begin
        w_acc_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= {CW{1'b0}};
      r_div     <= 1'b0;
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
`ifdef MDU_DIVZERO_EN
      r_divz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
`ifdef MDU_DIVZERO_EN
      r_divz <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_div     <= bus.op[1];
            r_a       <= w_a_mag;
            r_b       <= w_b_mag;
            r_neg     <= w_signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            r_rem_neg <= w_signed & bus.SrcA[WIDTH-1];
            r_acc     <= bus.op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {(2*WIDTH){1'b0}};
            r_cnt     <= {CW{1'b0}};
          end else begin
            if (bus.hi_we) begin
              r_hi <= bus.WD;
            end
            if (bus.lo_we) begin
              r_lo <= bus.WD;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CW'(1);
          if (!r_div) begin
            r_b <= r_b >> 1;
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_div) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (w_div0) begin
`ifdef MDU_DIVZERO_EN
            r_divz <= 1'b1;
`else
            r_lo <= {WIDTH{1'b1}};
            r_hi <= w_a_raw;
`endif
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized stimulus against an arithmetic model of mdu_hilo, plus literal pins.
// Honours MDU_DIVZERO_EN for the divide-by-zero expectations.
`timescale 1ns/1ps
module tb_mdu_hilo;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  mdu_hilo_if #(.WIDTH(W)) u_if ();

  mdu_hilo #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done, m_dz, p_dz;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: the result an op must leave in HI/LO.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    hi = cur_hi;
    lo = cur_lo;
    sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    if (!op[1]) begin
      p  = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
`ifdef MDU_DIVZERO_EN
      dz = 1'b1;
`else
      lo = 32'hFFFF_FFFF;
      hi = a;
`endif
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // Compare DUT against the model each cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_cnt = 0;
    end
    check("busy", 32'(u_if.busy), 32'(m_busy));
    check("done", 32'(u_if.done), 32'(m_done));
    check("HI", u_if.HI, m_hi);
    check("LO", u_if.LO, m_lo);
`ifdef MDU_DIVZERO_EN
    check("divzero", 32'(u_if.divzero), 32'(m_dz));
`endif
    if (reset_n) begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_dz   = p_dz;
          if (!p_dz) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (u_if.start) begin
        model_op(u_if.op, u_if.SrcA, u_if.SrcB, m_hi, m_lo, p_hi, p_lo, p_dz);
        m_cnt  = 33;
        m_busy = 1'b1;
      end else begin
        if (u_if.hi_we) m_hi = u_if.WD;
        if (u_if.lo_we) m_lo = u_if.WD;
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (optionally with a same-cycle direct write) and wait, bounded, for done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit with_we);
    int edges;
    u_if.start = 1'b1; u_if.op = op; u_if.SrcA = a; u_if.SrcB = b;
    u_if.hi_we = with_we; u_if.lo_we = with_we; u_if.WD = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.hi_we = 1'b0; u_if.lo_we = 1'b0;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (u_if.done) break;
      if (noise) begin
        u_if.start = 1'($urandom); u_if.op = 2'($urandom);
        u_if.SrcA = $urandom; u_if.SrcB = $urandom;
        u_if.hi_we = 1'($urandom); u_if.lo_we = 1'($urandom); u_if.WD = $urandom;
      end
    end
    u_if.start = 1'b0; u_if.hi_we = 1'b0; u_if.lo_we = 1'b0;
    check("latency", 32'(edges), 32'd33);
  endtask

  task automatic idle_write(input bit hw, input bit lw, input logic [31:0] wd);
    u_if.hi_we = hw; u_if.lo_we = lw; u_if.WD = wd;
    @(posedge clk); #1;
    u_if.hi_we = 1'b0; u_if.lo_we = 1'b0;
  endtask

  initial begin
    int edges;
    reset_n = 1'b0;
    u_if.start = 1'b0; u_if.op = 2'b00; u_if.SrcA = 32'd0; u_if.SrcB = 32'd0;
    u_if.hi_we = 1'b0; u_if.lo_we = 1'b0; u_if.WD = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_HI", u_if.HI, 32'd0);
    check("rst_LO", u_if.LO, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_HI", u_if.HI, 32'hFFFF_FFFE);
    check("multu_LO", u_if.LO, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_HI", u_if.HI, 32'hFFFF_FFFF);
    check("mult_LO", u_if.LO, 32'hFFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_LO", u_if.LO, 32'hFFFF_FFFD);
    check("div_HI", u_if.HI, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_LO", u_if.LO, 32'd14);
    check("divu_HI", u_if.HI, 32'd2);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("divovf_LO", u_if.LO, 32'h8000_0000);
    check("divovf_HI", u_if.HI, 32'd0);

    // start and hi_we landing at E10 of a running op must both be ignored
    u_if.start = 1'b1; u_if.op = 2'b00; u_if.SrcA = 32'hFFFF_FFFD; u_if.SrcB = 32'd7;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (u_if.done) break;
      if (edges == 9) begin
        u_if.start = 1'b1; u_if.op = 2'b11; u_if.SrcA = 32'd5; u_if.SrcB = 32'd1;
        u_if.hi_we = 1'b1; u_if.WD = 32'h0000_1234;
      end else begin
        u_if.start = 1'b0; u_if.hi_we = 1'b0;
      end
    end
    u_if.start = 1'b0; u_if.hi_we = 1'b0;
    check("ign_latency", 32'(edges), 32'd33);
    check("ign_HI", u_if.HI, 32'hFFFF_FFFF);
    check("ign_LO", u_if.LO, 32'hFFFF_FFEB);
    idle_write(1'b1, 1'b0, 32'h0000_1234);
    check("mthi_HI", u_if.HI, 32'h0000_1234);
    check("mthi_LO", u_if.LO, 32'hFFFF_FFEB);
    idle_write(1'b1, 1'b1, 32'hCAFE_0001);
    check("both_HI", u_if.HI, 32'hCAFE_0001);
    check("both_LO", u_if.LO, 32'hCAFE_0001);

    run_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b1);
    check("prio_HI", u_if.HI, 32'd0);
    check("prio_LO", u_if.LO, 32'd6);
    idle_write(1'b1, 1'b0, 32'h5555_AAAA);

    // asynchronous reset after E15 of a running multiply
    u_if.start = 1'b1; u_if.op = 2'b01; u_if.SrcA = 32'hFFFF_FFFF; u_if.SrcB = 32'd3;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("mid_busy", 32'(u_if.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(u_if.busy), 32'd0);
    check("arst_done", 32'(u_if.done), 32'd0);
    check("arst_HI", u_if.HI, 32'd0);
    check("arst_LO", u_if.LO, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    check("post_LO", u_if.LO, 32'd15);
    check("post_HI", u_if.HI, 32'd0);

    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b11, 32'd9, 32'd0, 1'b0, 1'b0);
`ifdef MDU_DIVZERO_EN
    check("dz_flag", 32'(u_if.divzero), 32'd1);
    check("dz_HI", u_if.HI, 32'd2);
    check("dz_LO", u_if.LO, 32'd14);
`else
    check("dz_LO", u_if.LO, 32'hFFFF_FFFF);
    check("dz_HI", u_if.HI, 32'd9);
`endif
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
`ifdef MDU_DIVZERO_EN
    check("sdz_flag", 32'(u_if.divzero), 32'd1);
    check("sdz_HI", u_if.HI, 32'd2);
    check("sdz_LO", u_if.LO, 32'd14);
`else
    check("sdz_LO", u_if.LO, 32'hFFFF_FFFF);
    check("sdz_HI", u_if.HI, 32'hFFFF_FFF9);
`endif

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle_write(1'($urandom), 1'($urandom), $urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      run_op(2'($urandom), pick(), ($urandom_range(0, 7) == 0) ? 32'd0 : pick(),
             1'b1, 1'($urandom));
    end
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
